// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program counter: produces the fetch address, handshakes it with
// instruction memory, and handles stall, redirects, trap entry/return and misaligned targets.
module pc_fetch_ctrl #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned     INCR         = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            j_signal,
   input  logic [XLEN-1:0] jump,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_vector,
   input  logic            mret,
   input  logic [XLEN-1:0] epc,
   input  logic            imem_ready,
   output logic [XLEN-1:0] out,
   output logic            out_valid,
   output logic [XLEN-1:0] pc_plus,
   output logic            misaligned,
   output logic [1:0]      o_dbg_state
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] INCR_X    = XLEN'(INCR);
   localparam logic [XLEN-1:0] ALIGN_MSK = ~(XLEN'(3));

   state_t            r_state;
   logic [XLEN-1:0]   r_out;
   logic              r_out_valid;
   logic              r_misaligned;
   logic              r_pend_valid;
   logic [XLEN-1:0]   r_pend_tgt;

   state_t            w_state_nxt;
   logic [XLEN-1:0]   w_out_nxt;
   logic              w_out_valid_nxt;
   logic              w_mis_nxt;
   logic              w_pend_valid_nxt;
   logic [XLEN-1:0]   w_pend_tgt_nxt;

   logic              w_adv;
   logic [XLEN-1:0]   w_trap_tgt;
   logic              w_redirect;
   logic [XLEN-1:0]   w_tgt;
   logic              w_tgt_mis;

   assign w_adv      = imem_ready & ~stall;
   assign w_trap_tgt = trap_vector & ALIGN_MSK;
   assign pc_plus    = r_out + INCR_X;

   // Only the winning redirect's target is checked; a trap target is force-aligned
   // so a trap can never fault and always masks a misaligned mret/jump.
   always_comb begin
      w_redirect = 1'b0;
      w_tgt      = jump;
      w_tgt_mis  = 1'b0;
      if (trap) begin
         w_redirect = 1'b1;
         w_tgt      = w_trap_tgt;
      end else if (mret) begin
         w_redirect = 1'b1;
         w_tgt      = epc;
         w_tgt_mis  = |epc[1:0];
      end else if (j_signal) begin
         w_redirect = 1'b1;
         w_tgt      = jump;
         w_tgt_mis  = |jump[1:0];
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_out_nxt        = r_out;
      w_mis_nxt        = 1'b0;
      w_pend_valid_nxt = r_pend_valid;
      w_pend_tgt_nxt   = r_pend_tgt;
      case (r_state)
         ST_BOOT: begin
            w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (w_tgt_mis) begin
               w_state_nxt      = ST_FAULT;
               w_mis_nxt        = 1'b1;
               w_pend_valid_nxt = 1'b0;
            end else if (w_redirect) begin
               if (w_adv) begin
                  w_out_nxt        = w_tgt;
                  w_pend_valid_nxt = 1'b0;
               end else begin
                  w_pend_tgt_nxt   = w_tgt;
                  w_pend_valid_nxt = 1'b1;
               end
            end else if (w_adv) begin
               if (r_pend_valid) begin
                  w_out_nxt        = r_pend_tgt;
                  w_pend_valid_nxt = 1'b0;
               end else begin
                  w_out_nxt = pc_plus;
               end
            end
         end
         ST_FAULT: begin
            // Only a trap leaves FAULT; the handler address is fetched on that edge.
            if (trap) begin
               w_state_nxt = ST_RUN;
               w_out_nxt   = w_trap_tgt;
            end
         end
         default: begin
            w_state_nxt = ST_BOOT;
         end
      endcase
      w_out_valid_nxt = (w_state_nxt == ST_RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_BOOT;
         r_out        <= RESET_VECTOR;
         r_out_valid  <= 1'b0;
         r_misaligned <= 1'b0;
         r_pend_valid <= 1'b0;
         r_pend_tgt   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_out        <= w_out_nxt;
         r_out_valid  <= w_out_valid_nxt;
         r_misaligned <= w_mis_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_pend_tgt   <= w_pend_tgt_nxt;
      end
   end

   assign out         = r_out;
   assign out_valid   = r_out_valid;
   assign misaligned  = r_misaligned;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed, table-driven bench for pc_fetch_ctrl plus hand-written async-reset sequence.
module tb_pc_fetch_ctrl;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        j_signal;
   logic [31:0] jump;
   logic        trap;
   logic [31:0] trap_vector;
   logic        mret;
   logic [31:0] epc;
   logic        imem_ready;
   logic [31:0] out;
   logic        out_valid;
   logic [31:0] pc_plus;
   logic        misaligned;
   logic [1:0]  o_dbg_state;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      string       tag;
      logic        st;
      logic        rdy;
      logic        j;
      logic [31:0] jt;
      logic        tr;
      logic [31:0] tv;
      logic        mr;
      logic [31:0] ep;
      logic [31:0] eo;
      logic        ev;
      logic        em;
      logic [1:0]  es;
   } vec_t;

   vec_t tbl[$];

   pc_fetch_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .j_signal    (j_signal),
      .jump        (jump),
      .trap        (trap),
      .trap_vector (trap_vector),
      .mret        (mret),
      .epc         (epc),
      .imem_ready  (imem_ready),
      .out         (out),
      .out_valid   (out_valid),
      .pc_plus     (pc_plus),
      .misaligned  (misaligned),
      .o_dbg_state (o_dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial begin
      #100us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // In this bench out_valid=0 after reset release only happens in FAULT.
   function automatic vec_t mk(string tag, logic st, logic rdy, logic j, logic [31:0] jt,
                               logic tr, logic [31:0] tv, logic mr, logic [31:0] ep,
                               logic [31:0] eo, logic ev, logic em);
      vec_t v;
      v.tag = tag; v.st = st; v.rdy = rdy; v.j = j; v.jt = jt;
      v.tr = tr; v.tv = tv; v.mr = mr; v.ep = ep;
      v.eo = eo; v.ev = ev; v.em = em;
      v.es = ev ? 2'd1 : 2'd2;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      stall = 1'b0; j_signal = 1'b0; jump = '0; trap = 1'b0;
      trap_vector = '0; mret = 1'b0; epc = '0; imem_ready = 1'b1;
   endtask

   task automatic apply(int idx, vec_t v);
      logic [31:0] exp_plus;
      stall = v.st; imem_ready = v.rdy; j_signal = v.j; jump = v.jt;
      trap = v.tr; trap_vector = v.tv; mret = v.mr; epc = v.ep;
      @(posedge clk);
      @(negedge clk);
      exp_plus = v.eo + 32'd4;
      n_vec++;
      if (out !== v.eo || out_valid !== v.ev || misaligned !== v.em ||
          pc_plus !== exp_plus || o_dbg_state !== v.es) begin
         n_miss++;
         $display("FAIL vec %0d (%s): out=%h/%h valid=%b/%b mis=%b/%b pc_plus=%h/%h state=%0d/%0d (got/expected)",
                  idx, v.tag, out, v.eo, out_valid, v.ev, misaligned, v.em,
                  pc_plus, exp_plus, o_dbg_state, v.es);
      end
   endtask

   initial begin
      //            tag        st rdy j  jt            tr tv          mr ep          exp_out       ev em
      tbl.push_back(mk("run0",   0, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h0,        1, 0));
      tbl.push_back(mk("run4",   0, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h4,        1, 0));
      tbl.push_back(mk("run8",   0, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h8,        1, 0));
      tbl.push_back(mk("runC",   0, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'hC,        1, 0));
      tbl.push_back(mk("jmp",    0, 1, 1, 32'h100,     0, 32'h0,     0, 32'h0,     32'h100,      1, 0));
      tbl.push_back(mk("stall1", 1, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h100,      1, 0));
      tbl.push_back(mk("stall2", 1, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h100,      1, 0));
      tbl.push_back(mk("stall3", 1, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h100,      1, 0));
      tbl.push_back(mk("resume", 0, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h104,      1, 0));
      tbl.push_back(mk("nrdy",   0, 0, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h104,      1, 0));
      tbl.push_back(mk("bufj",   0, 0, 1, 32'h200,     0, 32'h0,     0, 32'h0,     32'h104,      1, 0));
      tbl.push_back(mk("bufidl", 0, 0, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h104,      1, 0));
      tbl.push_back(mk("bufmrt", 0, 0, 0, 32'h0,       0, 32'h0,     1, 32'h300,   32'h104,      1, 0));
      tbl.push_back(mk("drain",  0, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h300,      1, 0));
      tbl.push_back(mk("after",  0, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h304,      1, 0));
      tbl.push_back(mk("prio",   0, 1, 1, 32'h500,     1, 32'h80,    1, 32'h300,   32'h80,       1, 0));
      tbl.push_back(mk("prio83", 0, 1, 1, 32'h500,     1, 32'h83,    1, 32'h300,   32'h80,       1, 0));
      tbl.push_back(mk("seq",    0, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h84,       1, 0));
      tbl.push_back(mk("bufj2",  0, 0, 1, 32'h600,     0, 32'h0,     0, 32'h0,     32'h84,       1, 0));
      tbl.push_back(mk("newwin", 0, 1, 1, 32'h700,     0, 32'h0,     0, 32'h0,     32'h700,      1, 0));
      tbl.push_back(mk("nostal", 0, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h704,      1, 0));
      tbl.push_back(mk("misj",   0, 1, 1, 32'h102,     0, 32'h0,     0, 32'h0,     32'h704,      0, 1));
      tbl.push_back(mk("fidle",  0, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h704,      0, 0));
      tbl.push_back(mk("fjmp",   0, 1, 1, 32'h400,     0, 32'h0,     0, 32'h0,     32'h704,      0, 0));
      tbl.push_back(mk("fmret",  0, 1, 0, 32'h0,       0, 32'h0,     1, 32'h500,   32'h704,      0, 0));
      tbl.push_back(mk("ftrap",  0, 1, 0, 32'h0,       1, 32'h40,    0, 32'h0,     32'h40,       1, 0));
      tbl.push_back(mk("fseq",   0, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h44,       1, 0));
      tbl.push_back(mk("bufj3",  0, 0, 1, 32'h600,     0, 32'h0,     0, 32'h0,     32'h44,       1, 0));
      tbl.push_back(mk("misbuf", 0, 0, 1, 32'h601,     0, 32'h0,     0, 32'h0,     32'h44,       0, 1));
      tbl.push_back(mk("ftrap2", 0, 1, 0, 32'h0,       1, 32'h48,    0, 32'h0,     32'h48,       1, 0));
      tbl.push_back(mk("clrpnd", 0, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h4C,       1, 0));
      tbl.push_back(mk("mismrt", 1, 1, 0, 32'h0,       0, 32'h0,     1, 32'h302,   32'h4C,       0, 1));
      tbl.push_back(mk("ftrpst", 1, 1, 0, 32'h0,       1, 32'h41,    0, 32'h0,     32'h40,       1, 0));
      tbl.push_back(mk("seq2",   0, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h44,       1, 0));
      tbl.push_back(mk("trpwin", 0, 1, 1, 32'h103,     1, 32'h90,    0, 32'h0,     32'h90,       1, 0));
      tbl.push_back(mk("wrapj",  0, 1, 1, 32'hFFFFFFFC, 0, 32'h0,    0, 32'h0,     32'hFFFFFFFC, 1, 0));
      tbl.push_back(mk("wrap",   0, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h0,        1, 0));
      tbl.push_back(mk("buftrp", 0, 0, 0, 32'h0,       1, 32'h123,   0, 32'h0,     32'h0,        1, 0));
      tbl.push_back(mk("drain2", 0, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h120,      1, 0));
      tbl.push_back(mk("seq3",   0, 1, 0, 32'h0,       0, 32'h0,     0, 32'h0,     32'h124,      1, 0));

      // Reset phase: held high through 80 ns.
      reset = 1'b1;
      drive_idle();
      repeat (3) @(negedge clk);
      chk("rst_out",   out,                 32'h0);
      chk("rst_valid", {31'b0, out_valid},  32'h0);
      chk("rst_mis",   {31'b0, misaligned}, 32'h0);
      chk("rst_state", {30'b0, o_dbg_state}, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

      // Async reset while a redirect is pending, then confirm it is not replayed.
      drive_idle();
      imem_ready = 1'b0; j_signal = 1'b1; jump = 32'h800;
      @(posedge clk);
      @(negedge clk);
      chk("pend_hold", out, 32'h124);
      j_signal = 1'b0;
      #3 reset = 1'b1;
      #1;
      chk("arst_out",   out,                  32'h0);
      chk("arst_valid", {31'b0, out_valid},   32'h0);
      chk("arst_state", {30'b0, o_dbg_state}, 32'h0);
      #2 reset = 1'b0;
      imem_ready = 1'b1; trap = 1'b1; trap_vector = 32'h40;
      @(posedge clk);
      @(negedge clk);
      chk("boot_out",   out,                {31'b0, 1'b0});
      chk("boot_valid", {31'b0, out_valid}, 32'h1);
      trap = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("no_stale", out, 32'h4);
      chk("no_stale_plus", pc_plus, 32'h8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
